// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, multiply, branch-flush and dcache-freeze
// scheduler for the five-stage pipeline.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   IFID_RegRs_i/IFID_RegRt_i : sources of instruction in ID
//   IDEX_MemRead_i/IDEX_RegRt_i/IDEX_Mul_i : instruction in EX
//   Branch_taken_i : branch in ID resolved taken
//   Dmem_stall_i   : data cache miss pending
//   PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
//   EX_hold_o, Freeze_o, Mul_busy_o : pipeline controls
//   Stall_cnt_o    : cycles with PC_write_o low
//
// Parameters: MUL_LAT (2..16), CNT_W.
// Optional feature: define HAZ_STALL_CNT_EN to build the
// saturating stall counter; otherwise Stall_cnt_o is 0.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RegRs_i,
  input  logic [4:0]       IFID_RegRt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegRt_i,
  input  logic             IDEX_Mul_i,
  input  logic             Branch_taken_i,
  input  logic             Dmem_stall_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             EX_hold_o,
  output logic             Freeze_o,
  output logic             Mul_busy_o,
  output logic [CNT_W-1:0] Stall_cnt_o
);

  typedef enum logic {
    S_RUN = 1'b0,
    S_MUL = 1'b1
  } state_e;

  // First hold happens in RUN, so MUL covers the remaining
  // MUL_LAT-2 holds plus one release cycle.
  localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 2);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] mcnt_q;
  logic [3:0] mcnt_d;

  logic in_mul;
  logic mul_hold;
  logic load_use;
  logic rs_hit;
  logic rt_hit;

  logic sel_frz;
  logic sel_mul;
  logic sel_lu;
  logic sel_br;

  assign in_mul = (state_q == S_MUL);

  // In MUL the opcode in EX is ignored; the countdown
  // alone decides whether the hold continues.
  assign mul_hold = in_mul ? (mcnt_q != 4'd0)
                           : IDEX_Mul_i;

  assign rs_hit = (IDEX_RegRt_i == IFID_RegRs_i);
  assign rt_hit = (IDEX_RegRt_i == IFID_RegRt_i);

  assign load_use = IDEX_MemRead_i
                  & (IDEX_RegRt_i != 5'd0)
                  & (rs_hit | rt_hit);

  // One-hot selection in priority order; reset masks all.
  assign sel_frz = rst_i & Dmem_stall_i;
  assign sel_mul = rst_i & ~Dmem_stall_i & mul_hold;
  assign sel_lu  = rst_i & ~Dmem_stall_i & ~mul_hold
                 & load_use;
  assign sel_br  = rst_i & ~Dmem_stall_i & ~mul_hold
                 & ~load_use & Branch_taken_i;

  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    EX_hold_o     = 1'b0;
    Freeze_o      = 1'b0;
    unique case (1'b1)
      sel_frz: begin
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        EX_hold_o    = 1'b1;
        Freeze_o     = 1'b1;
      end
      sel_mul: begin
        PC_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        EX_hold_o    = 1'b1;
      end
      sel_lu: begin
        PC_write_o    = 1'b0;
        IFID_write_o  = 1'b0;
        IDEX_bubble_o = 1'b1;
      end
      sel_br: begin
        IFID_flush_o = 1'b1;
      end
      default: begin
        PC_write_o = 1'b1;
      end
    endcase
  end

  assign Mul_busy_o = in_mul;

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (!Dmem_stall_i) begin
      unique case (state_q)
        S_RUN: begin
          if (IDEX_Mul_i) begin
            state_d = S_MUL;
            mcnt_d  = MCNT_INIT;
          end
        end
        S_MUL: begin
          if (mcnt_q != 4'd0) begin
            mcnt_d = mcnt_q - 4'd1;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
          mcnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RUN;
      mcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!PC_write_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Stall_cnt_o = cnt_q;
`else
  assign Stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (MUL_LAT 4 and 2)
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int LAT_A = 4;
  localparam int LAT_B = 2;
  localparam int MAX_A = 15;
  localparam int MAX_B = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs, rt, exrt;
  logic       memrd, mul, br, dm;

  logic a_pc, a_ifw, a_fl, a_bub, a_hold, a_frz, a_busy;
  logic b_pc, b_ifw, b_fl, b_bub, b_hold, b_frz, b_busy;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;

  wire [6:0] a_vec = {a_pc, a_ifw, a_fl, a_bub,
                      a_hold, a_frz, a_busy};
  wire [6:0] b_vec = {b_pc, b_ifw, b_fl, b_bub,
                      b_hold, b_frz, b_busy};

  hazard_ctrl #(.MUL_LAT(LAT_A), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .IFID_RegRs_i(rs), .IFID_RegRt_i(rt),
    .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(exrt),
    .IDEX_Mul_i(mul), .Branch_taken_i(br),
    .Dmem_stall_i(dm),
    .PC_write_o(a_pc), .IFID_write_o(a_ifw),
    .IFID_flush_o(a_fl), .IDEX_bubble_o(a_bub),
    .EX_hold_o(a_hold), .Freeze_o(a_frz),
    .Mul_busy_o(a_busy), .Stall_cnt_o(a_cnt)
  );

  hazard_ctrl #(.MUL_LAT(LAT_B), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .IFID_RegRs_i(rs), .IFID_RegRt_i(rt),
    .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(exrt),
    .IDEX_Mul_i(mul), .Branch_taken_i(br),
    .Dmem_stall_i(dm),
    .PC_write_o(b_pc), .IFID_write_o(b_ifw),
    .IFID_flush_o(b_fl), .IDEX_bubble_o(b_bub),
    .EX_hold_o(b_hold), .Freeze_o(b_frz),
    .Mul_busy_o(b_busy), .Stall_cnt_o(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model: rem = cycles left in the multiply sequence
  // (last one is the release cycle); cnt = stall cycles.
  int rem_a = 0, rem_b = 0;
  int cnt_a = 0, cnt_b = 0;
  logic [6:0] ea, eb;
  logic [3:0]  eca;
  logic [15:0] ecb;

  localparam logic [6:0] IDLE = 7'b1100000;

  function automatic logic [6:0] ctl(input int rem);
    logic lu;
    logic bz;
    lu = memrd && (exrt != 0)
         && (exrt == rs || exrt == rt);
    bz = (rem > 0);
    if (!rst_n) return IDLE;
    if (dm) return {6'b000011, bz};
    if (rem > 1 || (rem == 0 && mul))
      return {6'b000010, bz};
    if (lu) return {6'b000100, bz};
    if (br) return {6'b111000, bz};
    return {6'b110000, bz};
  endfunction

  function automatic int nrem(input int rem,
                              input int lat);
    if (!rst_n) return 0;
    if (dm) return rem;
    if (rem > 0) return rem - 1;
    if (mul) return lat - 1;
    return 0;
  endfunction

  function automatic int ncnt(input int c,
                              input logic pc,
                              input int mx);
    if (!rst_n) return 0;
    if (!pc && c < mx) return c + 1;
    return c;
  endfunction

  task automatic step(input logic r,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic mr, input logic [4:0] er,
                      input logic m, input logic b,
                      input logic d);
    @(negedge clk);
    rst_n = r; rs = s; rt = t; memrd = mr;
    exrt = er; mul = m; br = b; dm = d;
    #1;
    ea = ctl(rem_a);
    eb = ctl(rem_b);
`ifdef HAZ_STALL_CNT_EN
    eca = cnt_a[3:0];
    ecb = cnt_b[15:0];
`else
    eca = '0;
    ecb = '0;
`endif
  endtask

  task automatic advance();
    cnt_a = ncnt(cnt_a, ea[6], MAX_A);
    cnt_b = ncnt(cnt_b, eb[6], MAX_B);
    rem_a = nrem(rem_a, LAT_A);
    rem_b = nrem(rem_b, LAT_B);
    @(posedge clk);
  endtask

  task automatic test_reset();
    step(0, 5'd2, 5'd2, 0, 5'd2, 1, 1, 1);
    checks++;
    if (a_vec !== IDLE || b_vec !== IDLE) begin
      failures++;
      $display("FAIL reset_ctl a=%b b=%b want=%b",
               a_vec, b_vec, IDLE);
    end
    checks++;
    if (a_cnt !== 4'd0 || b_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt a=%0d b=%0d want=0",
               a_cnt, b_cnt);
    end
    advance();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec !== IDLE) begin
      failures++;
      $display("FAIL reset_idle a=%b want=%b",
               a_vec, IDLE);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [6:0] want;
    step(1, 5'd2, 5'd7, 1, 5'd2, 0, 0, 0);
    want = 7'b0001000;
    checks++;
    if (a_vec !== want || a_vec !== ea) begin
      failures++;
      $display("FAIL lu_rs a=%b want=%b", a_vec, want);
    end
    advance();
    step(1, 5'd2, 5'd7, 0, 5'd0, 0, 0, 0);
    checks++;
    if (a_vec !== IDLE) begin
      failures++;
      $display("FAIL lu_after a=%b want=%b",
               a_vec, IDLE);
    end
    advance();
    step(1, 5'd3, 5'd9, 1, 5'd9, 0, 0, 0);
    checks++;
    if (b_vec !== 7'b0001000) begin
      failures++;
      $display("FAIL lu_rt b=%b want=0001000", b_vec);
    end
    advance();
    step(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    checks++;
    if (a_vec !== IDLE || b_vec !== IDLE) begin
      failures++;
      $display("FAIL lu_r0 a=%b b=%b want=%b",
               a_vec, b_vec, IDLE);
    end
    advance();
  endtask

  task automatic test_mul();
    int ha = 0, hb = 0, ba = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, (i == 0), 0, 0);
      ha += int'(a_hold);
      hb += int'(b_hold);
      ba += int'(a_busy);
      checks++;
      if (a_vec !== ea || b_vec !== eb) begin
        failures++;
        $display("FAIL mul c%0d a=%b/%b b=%b/%b",
                 i, a_vec, ea, b_vec, eb);
      end
      advance();
    end
    checks++;
    if (ha != 3 || hb != 1 || ba != 3) begin
      failures++;
      $display("FAIL mul_len ha=%0d hb=%0d ba=%0d want 3/1/3",
               ha, hb, ba);
    end
  endtask

  task automatic test_freeze_mul();
    int h = 0, f = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, (i == 0), 0,
           (i >= 1 && i <= 5));
      if (a_hold && !a_frz) h++;
      f += int'(a_frz);
      checks++;
      if (a_vec !== ea || b_vec !== eb) begin
        failures++;
        $display("FAIL frzmul c%0d a=%b/%b b=%b/%b",
                 i, a_vec, ea, b_vec, eb);
      end
      advance();
    end
    checks++;
    if (h != 3 || f != 5) begin
      failures++;
      $display("FAIL frzmul_len holds=%0d frz=%0d want 3/5",
               h, f);
    end
  endtask

  task automatic test_branch_block();
    step(1, 5'd4, 5'd1, 1, 5'd4, 0, 1, 0);
    checks++;
    if (a_fl !== 1'b0 || a_bub !== 1'b1) begin
      failures++;
      $display("FAIL br_blk fl=%b bub=%b want 0/1",
               a_fl, a_bub);
    end
    advance();
    step(1, 5'd4, 5'd1, 0, 5'd0, 0, 1, 0);
    checks++;
    if (a_vec !== 7'b1110000) begin
      failures++;
      $display("FAIL br_next a=%b want=1110000", a_vec);
    end
    advance();
  endtask

  task automatic test_reset_mid_mul();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, (i == 0), 0, 0);
      advance();
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (a_busy !== 1'b0 || a_pc !== 1'b1) begin
      failures++;
      $display("FAIL rst_mul busy=%b pc=%b want 0/1",
               a_busy, a_pc);
    end
    advance();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec !== IDLE || a_vec !== ea) begin
      failures++;
      $display("FAIL rst_mul_after a=%b want=%b",
               a_vec, IDLE);
    end
    advance();
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 1);
      advance();
    end
    step(1, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZ_STALL_CNT_EN
    want = 4'd15;
`else
    want = 4'd0;
`endif
    checks++;
    if (a_cnt !== want || a_cnt !== eca) begin
      failures++;
      $display("FAIL sat a_cnt=%0d want=%0d",
               a_cnt, want);
    end
    checks++;
    if (b_cnt !== ecb) begin
      failures++;
      $display("FAIL sat b_cnt=%0d want=%0d",
               b_cnt, ecb);
    end
    advance();
  endtask

  task automatic test_random();
    int k;
    logic r, mr, m, b, d;
    logic [4:0] s, t, e;
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 39) != 0);
      mr = (k == 1);
      m = (k == 2) && ($urandom_range(0, 2) == 0);
      b = $urandom_range(0, 1);
      d = ($urandom_range(0, 7) == 0);
      s = 5'($urandom_range(0, 3));
      t = 5'($urandom_range(0, 3));
      e = 5'($urandom_range(0, 3));
      step(r, s, t, mr, e, m, b, d);
      checks++;
      if (a_vec !== ea || b_vec !== eb) begin
        failures++;
        $display("FAIL rnd c%0d a=%b/%b b=%b/%b",
                 i, a_vec, ea, b_vec, eb);
      end
      checks++;
      if (a_cnt !== eca || b_cnt !== ecb) begin
        failures++;
        $display("FAIL rnd_cnt c%0d a=%0d/%0d b=%0d/%0d",
                 i, a_cnt, eca, b_cnt, ecb);
      end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs = '0; rt = '0; exrt = '0;
    memrd = 1'b0; mul = 1'b0;
    br = 1'b0; dm = 1'b0;
    test_reset();
    test_load_use();
    test_mul();
    test_freeze_mul();
    test_branch_block();
    test_reset_mid_mul();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
